// File: rtl/pc_fetch_stage.sv
// Program-counter and instruction-fetch stage: PC register, imem req/ack handshake, IF/ID register
// with a one-entry hold buffer for decode stall. Optional FETCH_COUNT_EN adds a delivery counter.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc_in,
    input  logic        redirect,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] pc_add_4,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
`ifdef FETCH_COUNT_EN
    output logic [31:0] fetch_count,
`endif
    output logic        instr_valid
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_valid;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;

    logic        w_load;
    logic [31:0] w_load_instr;
    logic [31:0] w_load_pc;

    // IF/ID is written either straight from memory or by draining the hold buffer.
    assign w_load = !redirect && !stall &&
                    (((r_state == ST_REQ) && imem_ack) || (r_state == ST_HOLD));
    assign w_load_instr = (r_state == ST_HOLD) ? r_hold_instr : imem_data;
    assign w_load_pc    = (r_state == ST_HOLD) ? r_hold_pc    : r_pc;

    assign imem_req    = (r_state == ST_REQ);
    assign imem_addr   = r_pc;
    assign pc_add_4    = r_pc + PC_STEP;
    assign instr_out   = r_instr;
    assign pc_out      = r_pc_out;
    assign instr_valid = r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_instr      <= 32'h0;
            r_pc_out     <= 32'h0;
            r_valid      <= 1'b0;
            r_hold_instr <= 32'h0;
            r_hold_pc    <= 32'h0;
        end else if (redirect) begin
            // Flush: any ack this cycle and any held instruction are dropped.
            r_state      <= ST_IDLE;
            r_pc         <= next_pc_in;
            r_valid      <= 1'b0;
            r_hold_instr <= 32'h0;
            r_hold_pc    <= 32'h0;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (imem_ack) begin
                        r_pc <= next_pc_in;
                        if (stall) begin
                            r_hold_instr <= imem_data;
                            r_hold_pc    <= r_pc;
                            r_state      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        r_state <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_REQ;
                end
            endcase

            if (w_load) begin
                r_instr  <= w_load_instr;
                r_pc_out <= w_load_pc;
                r_valid  <= 1'b1;
            end else if (!stall) begin
                r_valid  <= 1'b0;
            end
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] r_fetch_count;

    assign fetch_count = r_fetch_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= 32'h0;
        end else if (w_load) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed stimulus, a transaction-level reference model
// compared every cycle, plus literal spot checks. Define FETCH_COUNT_EN to cover the counter.
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc_in;
    logic        redirect;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] pc_add_4;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    logic        use_tgt;
    logic [31:0] tgt;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    // Memory returns addr + 0x100; next_pc_in follows pc_add_4 unless a target is forced.
    assign imem_data  = imem_addr + 32'h100;
    assign next_pc_in = use_tgt ? tgt : pc_add_4;

    pc_fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .next_pc_in (next_pc_in),
        .redirect   (redirect),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .pc_add_4   (pc_add_4),
        .instr_out  (instr_out),
        .pc_out     (pc_out),
`ifdef FETCH_COUNT_EN
        .fetch_count(fetch_count),
`endif
        .instr_valid(instr_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch engine is either restarting (bubble), parked on a held
    // instruction (queue non-empty), or actively requesting.
    logic        m_known = 1'b0;
    logic [31:0] m_pc;
    logic        m_bubble;
    logic [63:0] m_held[$];
    logic [31:0] m_instr, m_pcout, m_cnt;
    logic        m_valid;

    initial begin
        forever begin
            logic [31:0] nxt;
            logic [63:0] ent;
            @(negedge clk);
            if (m_known) begin
                check("imem_req", {31'h0, imem_req}, {31'h0, (!m_bubble && m_held.size() == 0)});
                if (!m_bubble && m_held.size() == 0) check("imem_addr", imem_addr, m_pc);
                check("pc_add_4", pc_add_4, m_pc + 32'd4);
                check("instr_valid", {31'h0, instr_valid}, {31'h0, m_valid});
                check("instr_out", instr_out, m_instr);
                check("pc_out", pc_out, m_pcout);
`ifdef FETCH_COUNT_EN
                check("fetch_count", fetch_count, m_cnt);
`endif
            end
            // Advance to the state after the coming rising edge.
            nxt = use_tgt ? tgt : m_pc + 32'd4;
            if (reset) begin
                m_known = 1'b1;
                m_pc = 32'h0; m_bubble = 1'b1; m_held.delete();
                m_valid = 1'b0; m_instr = 32'h0; m_pcout = 32'h0; m_cnt = 32'h0;
            end else if (m_known) begin
                if (redirect) begin
                    m_pc = nxt; m_valid = 1'b0; m_held.delete(); m_bubble = 1'b1;
                end else if (m_bubble) begin
                    m_bubble = 1'b0;
                    if (!stall) m_valid = 1'b0;
                end else if (m_held.size() != 0) begin
                    if (!stall) begin
                        ent = m_held.pop_front();
                        m_instr = ent[63:32]; m_pcout = ent[31:0]; m_valid = 1'b1; m_cnt++;
                    end
                end else if (imem_ack) begin
                    if (stall) begin
                        m_held.push_back({m_pc + 32'h100, m_pc});
                    end else begin
                        m_instr = m_pc + 32'h100; m_pcout = m_pc; m_valid = 1'b1; m_cnt++;
                    end
                    m_pc = nxt;
                end else if (!stall) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Inputs applied here are sampled on the next rising edge; returns 1 time unit after it.
    task automatic step(input logic r, input logic rd, input logic st, input logic ak,
                        input logic ut, input logic [31:0] tg);
        reset = r; redirect = rd; stall = st; imem_ack = ak; use_tgt = ut; tgt = tg;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; stall = 1'b0; imem_ack = 1'b0;
        use_tgt = 1'b0; tgt = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);

        // Streaming with a 3-cycle ack delay at pc=8.
        step(0, 0, 0, 1, 0, 0);
        check("lit_req_first", {31'h0, imem_req}, 32'h1);
        check("lit_addr0", imem_addr, 32'h0);
        step(0, 0, 0, 1, 0, 0);
        check("lit_instr0", instr_out, 32'h100);
        check("lit_valid0", {31'h0, instr_valid}, 32'h1);
        step(0, 0, 0, 1, 0, 0);
        check("lit_pcout4", pc_out, 32'h4);
        check("lit_addr8", imem_addr, 32'h8);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        check("lit_wait_valid", {31'h0, instr_valid}, 32'h0);
        check("lit_wait_addr", imem_addr, 32'h8);
        step(0, 0, 0, 1, 0, 0);
        check("lit_pcout8", pc_out, 32'h8);

        // Redirect to 0x40 coincident with an ack at pc=12.
        step(0, 1, 0, 1, 1, 32'h40);
        check("lit_redir_valid", {31'h0, instr_valid}, 32'h0);
        step(0, 0, 0, 1, 0, 0);
        check("lit_redir_addr", imem_addr, 32'h40);
        check("lit_redir_req", {31'h0, imem_req}, 32'h1);
        step(0, 0, 0, 1, 0, 0);
        check("lit_pcout40", pc_out, 32'h40);

        // Reset in the middle of a pending request, then stall with ack at pc=4.
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        check("lit_hold_req", {31'h0, imem_req}, 32'h0);
        check("lit_hold_pcout", pc_out, 32'h0);
        step(0, 0, 1, 1, 0, 0);
        check("lit_hold2_valid", {31'h0, instr_valid}, 32'h1);
        step(0, 0, 0, 1, 0, 0);
        check("lit_drain_pcout", pc_out, 32'h4);
        check("lit_drain_instr", instr_out, 32'h104);
        check("lit_resume_addr", imem_addr, 32'h8);
        step(0, 0, 0, 1, 0, 0);

        // Redirect and stall together while HOLD is occupied.
        step(0, 0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 1, 32'h80);
        check("lit_rs_valid", {31'h0, instr_valid}, 32'h0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("lit_rs_pcout", pc_out, 32'h80);

        // PC wrap from 0xFFFFFFFC.
        step(0, 1, 0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0);
        check("lit_wrap_add4", pc_add_4, 32'h0);
        step(0, 0, 0, 1, 0, 0);
        check("lit_wrap_pcout", pc_out, 32'hFFFF_FFFC);
        check("lit_wrap_addr", imem_addr, 32'h0);

        // Mixed pattern: stalls without ack, ack during stall, misaligned redirect target.
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 32'h0000_1233);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("lit_misalign_pcout", pc_out, 32'h0000_1237);
        step(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Program-counter and instruction-fetch stage.
- Sits directly upstream of branch_mux: supplies pc_add_4 to it, and takes its result_address back as next_pc_in.
- Holds the PC, runs a req/ack handshake to instruction memory, and delivers fetched instructions into the IF/ID register.
- Handles decode stall (via a one-entry hold buffer) and redirect flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, increment used for pc_add_4.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- next_pc_in  input  32  next fetch address (result_address from branch_mux).
- redirect  input  1  taken branch/bne resolved in decode; flush and reload PC.
- stall  input  1  decode cannot accept a new instruction this cycle.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address; equals pc while imem_req=1.
- imem_ack  input  1  imem_data valid this cycle; sampled only when imem_req=1.
- imem_data  input  32  instruction word.
- pc_add_4  output  32  combinational pc + PC_STEP, modulo 2^32; feeds branch_mux.
- instr_out  output  32  IF/ID instruction.
- pc_out  output  32  IF/ID PC of instr_out.
- instr_valid  output  1  IF/ID contents valid.

Behaviour:
- Reset (sync, active-high): pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr_out=0, pc_out=0, hold buffer cleared. Reset mid-handshake abandons the request; a late ack is ignored because imem_req=0.
- States: IDLE, REQ, HOLD. imem_req=1 only in REQ.
- IDLE: next state REQ. pc unchanged. Gives a one-cycle bubble after reset or redirect.
- REQ, imem_ack=0: stay in REQ; imem_addr stable.
- REQ, imem_ack=1, stall=0:
  - IF/ID <= {imem_data, pc}; instr_valid <= 1.
  - pc <= next_pc_in.
  - Stay in REQ, so back-to-back fetches give 1 instr/cycle with zero-wait memory.
- REQ, imem_ack=1, stall=1:
  - hold buffer <= {imem_data, pc}; pc <= next_pc_in.
  - Go to HOLD. IF/ID unchanged.
- HOLD, stall=1: hold everything; imem_req=0.
- HOLD, stall=0: IF/ID <= hold buffer; instr_valid <= 1; go to REQ.
- IF/ID consumption: whenever stall=0 and no new instruction is written this cycle, instr_valid <= 0 (instr_out/pc_out keep their last value). When stall=1, IF/ID holds.
- redirect=1, any state, highest priority:
  - pc <= next_pc_in; instr_valid <= 0; hold buffer discarded.
  - A simultaneous ack is discarded; state <= IDLE.
  - redirect wins over stall and ack in the same cycle.
- reset has priority over redirect.
- Latency: ack in cycle N -> instr_valid=1 in N+1 (no stall). Redirect in N -> imem_req=1 with the new address in N+2.
- Arithmetic: PC wraps 32'hFFFF_FFFC + 4 = 32'h0000_0000. No alignment checking; low bits pass through.

Optional Feature:
- Macro: FETCH_COUNT_EN.
- Defined:
  - Adds output fetch_count[31:0], reset to 0.
  - Increments by 1 each cycle a valid instruction is written into IF/ID (from REQ or HOLD).
  - Does not count redirect-discarded acks. Wraps at 2^32.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then ack held 1, stall=0, next_pc_in=pc_add_4, RESET_PC=0, imem_data=addr+32'h100 -> imem_addr 0,4,8,… on consecutive cycles; instr_out 32'h100, 32'h104, … with pc_out 0,4,…; instr_valid=1 from the 3rd cycle after reset release.
- Ack delayed 3 cycles at pc=8 -> imem_addr held at 8 for 3 cycles, instr_valid=0 during wait, pc_out=8 the cycle after ack.
- stall=1 coincident with ack at pc=4, stall held 2 cycles -> IF/ID keeps the pc=0 instr, imem_req=0 in HOLD; on stall release instr from pc=4 appears, then fetch resumes at next_pc_in=8.
- redirect=1 with next_pc_in=32'h40 while ack=1 at pc=12 -> instr_valid=0 next cycle, pc=12 data never delivered, imem_addr=32'h40 two cycles later.
- redirect and stall both 1 while in HOLD -> hold buffer dropped, next delivered pc_out equals redirect target.
- With FETCH_COUNT_EN, 5 delivered + 1 flushed ack -> fetch_count=5; reset mid-run -> 0.
